// File: rtl/keyb_scanner_pkg.sv
// Shared types, key-code width helper and the default 4x4 calculator legend
// for the keypad scanner and the keyb_iface decode logic.
package keyb_pkg;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_t;
  typedef enum logic {IDLE, HELD} fsm_t;

  function automatic int keyWidth(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Default legend, code = row*4 + col:
  //   7 8 9 /   4 5 6 *   1 2 3 -   C 0 = +
  localparam logic [3:0] KEY_DIGIT [10] = '{4'd13, 4'd8, 4'd9, 4'd10, 4'd4,
                                            4'd5,  4'd6, 4'd0, 4'd1,  4'd2};
  localparam logic [3:0] KEY_DIV = 4'd3;
  localparam logic [3:0] KEY_MUL = 4'd7;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_ADD = 4'd15;
  localparam logic [3:0] KEY_CLR = 4'd12;
  localparam logic [3:0] KEY_EQ  = 4'd14;

endpackage

// File: rtl/keyb_scanner_if.sv
// Keypad pin bundle plus the committed-key outputs; master is the scanner side.
interface keyb_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  import keyb_pkg::*;
  localparam int KW = keyWidth(ROWS, COLS);

  logic [ROWS-1:0] rows;
  logic [COLS-1:0] cols;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_pulse;
  logic            multi_key;

  modport master (input rows, output cols, key_code, key_valid, key_pulse, multi_key);
  modport slave  (output rows, input cols, key_code, key_valid, key_pulse, multi_key);
endinterface

// File: rtl/keyb_sync.sv
// W-wide two-flop synchroniser for the asynchronous row sense lines.
module keyb_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/keyb_scanner.sv
// Matrix keypad scanner: column drive, whole-scan debounce, chord rejection,
// press pulse / held level and optional auto-repeat.
module keyb_scanner
  import keyb_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DELAY = 60,
  parameter int REPEAT_RATE  = 10
) (
  input logic            clk,
  input logic            rst,
  keyb_scanner_if.master bus
);
  localparam int KW   = keyWidth(ROWS, COLS);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW   = $clog2(DEBOUNCE + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [ROWS-1:0] rowsSync;
  logic [DW-1:0]   dwell;
  logic [CW-1:0]   colIdx;
  logic [COLS-1:0] colsQ;
  logic [1:0]      accCnt, nxtCnt;
  logic [KW-1:0]   accCode, nxtCode, prevCode;
  scan_res_t       curRes, prevRes;
  logic [SW-1:0]   stab, nxtStab;
  logic            colLast, scanEnd, sameRes, commit;

  fsm_t            state;
  logic [RW-1:0]   rptCnt;
  logic [KW-1:0]   keyCode;
  logic            keyValid, keyPulse, multiKey;

  keyb_sync #(.W(ROWS)) uSync (.clk(clk), .rst(rst), .d(bus.rows), .q(rowsSync));

  assign colLast = (dwell == DW'(SCAN_DIV - 1));
  assign scanEnd = colLast && (colIdx == CW'(COLS - 1));

  // Column 0 starts from an empty accumulator; the first key found keeps its code.
  always_comb begin
    nxtCnt  = (colIdx == '0) ? 2'd0 : accCnt;
    nxtCode = (colIdx == '0) ? '0   : accCode;
    for (int r = 0; r < ROWS; r++)
      if (rowsSync[r]) begin
        if (nxtCnt == 2'd0) nxtCode = KW'(r * COLS) + KW'(colIdx);
        if (nxtCnt != 2'd2) nxtCnt = nxtCnt + 2'd1;
      end
    curRes  = (nxtCnt == 2'd0) ? NONE : (nxtCnt == 2'd1) ? SINGLE : MULTI;
    sameRes = (curRes == prevRes) && (curRes != SINGLE || nxtCode == prevCode);
    nxtStab = !sameRes ? SW'(1) : (stab == SW'(DEBOUNCE)) ? stab : stab + SW'(1);
    commit  = (nxtStab == SW'(DEBOUNCE));
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dwell    <= '0;
      colIdx   <= '0;
      colsQ    <= COLS'(1);
      accCnt   <= 2'd0;
      accCode  <= '0;
      prevRes  <= NONE;
      prevCode <= '0;
      stab     <= '0;
    end else begin
      dwell <= colLast ? '0 : dwell + DW'(1);
      if (colLast) begin
        colIdx  <= (colIdx == CW'(COLS - 1)) ? '0 : colIdx + CW'(1);
        colsQ   <= {colsQ[COLS-2:0], colsQ[COLS-1]};
        accCnt  <= nxtCnt;
        accCode <= nxtCode;
      end
      if (scanEnd) begin
        prevRes  <= curRes;
        prevCode <= nxtCode;
        stab     <= nxtStab;
      end
    end

  // A committed release wins over a repeat due on the same scan end.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      keyCode  <= '0;
      keyValid <= 1'b0;
      keyPulse <= 1'b0;
      multiKey <= 1'b0;
      rptCnt   <= '0;
    end else begin
      keyPulse <= 1'b0;
      if (scanEnd) begin
        if (commit) multiKey <= (curRes == MULTI);
        case (state)
          IDLE:
            if (commit && curRes == SINGLE) begin
              state    <= HELD;
              keyCode  <= nxtCode;
              keyValid <= 1'b1;
              keyPulse <= 1'b1;
              rptCnt   <= RW'(REPEAT_DELAY);
            end
          HELD:
            if (commit && curRes == NONE) begin
              state    <= IDLE;
              keyValid <= 1'b0;
            end else if (REPEAT_EN) begin
              if (rptCnt == RW'(1)) begin
                keyPulse <= 1'b1;
                rptCnt   <= RW'(REPEAT_RATE);
              end else begin
                rptCnt <= rptCnt - RW'(1);
              end
            end
          default: state <= IDLE;
        endcase
      end
    end

  assign bus.cols      = colsQ;
  assign bus.key_code  = keyCode;
  assign bus.key_valid = keyValid;
  assign bus.key_pulse = keyPulse;
  assign bus.multi_key = multiKey;
endmodule

// File: tb/tb_keyb_scanner.sv
// Directed bench: two scanners (repeat off / on) on a modelled 4x4 keypad,
// pulses checked against a queue of expected (scan end, code) events.
module tb_keyb_scanner;
  localparam int ROWS = 4, COLS = 4, SD = 4, DB = 3, RD = 4, RR = 2;
  localparam int T = COLS * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keyb_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus0 ();
  keyb_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus1 ();

  keyb_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_EN(1'b0),
                 .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  keyb_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_EN(1'b1),
                 .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Keypad: a pressed key shorts its column line onto its row line.
  logic [ROWS*COLS-1:0] keys = '0;
  logic                 repOn = 1'b0;

  function automatic logic [ROWS-1:0] pad(input logic [ROWS*COLS-1:0] k, input logic [COLS-1:0] c);
    for (int r = 0; r < ROWS; r++) pad[r] = |(k[r*COLS +: COLS] & c);
  endfunction

  function automatic logic [ROWS*COLS-1:0] kb(input int code);
    kb = '0;
    kb[code] = 1'b1;
  endfunction

  assign bus0.rows = pad(keys, bus0.cols);
  assign bus1.rows = repOn ? pad(keys, bus1.cols) : '0;

  // Posedges since reset release; scan k ends on edge k*T.
  int cyc = 0;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  typedef struct { int scan; int code; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expPulse(input int id, input int scan, input int code);
    exp_t e;
    e.scan = scan;
    e.code = code;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic chkPulse(input int id, input int code);
    exp_t e;
    int   have;
    have = (id == 0) ? q0.size() : q1.size();
    tests++;
    assert (have > 0) else begin
      fails++;
      $error("FAIL pulse%0d_unexpected: observed pulse code %0d at cycle %0d expected none", id, code, cyc);
    end
    if (have > 0) begin
      if (id == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      check($sformatf("pulse%0d_time", id), cyc, e.scan * T);
      check($sformatf("pulse%0d_code", id), code, e.code);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.key_pulse === 1'b1) chkPulse(0, int'(bus0.key_code));
    if (bus1.key_pulse === 1'b1) chkPulse(1, int'(bus1.key_code));
  end

  task automatic toCyc(input int c);
    int guard = 0;
    while (cyc != c && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) check("wait_timeout", cyc, c);
  endtask

  task automatic toScan(input int k);
    toCyc(k * T);
  endtask

  task automatic chkRotation();
    int       at [5] = '{3, 4, 8, 12, 16};
    bit [3:0] oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      toCyc(at[i]);
      check($sformatf("cols_rot%0d", i), bus0.cols, oh[i]);
    end
  endtask

  initial begin
    rst = 1'b0;
    #12;
    check("rst_cols",  bus0.cols, 1);
    check("rst_code",  bus0.key_code, 0);
    check("rst_valid", bus0.key_valid, 0);
    check("rst_pulse", bus0.key_pulse, 0);
    check("rst_multi", bus0.multi_key, 0);
    @(negedge clk);
    rst = 1'b1;
    chkRotation();

    // Key 9 (row 2, col 1) pressed for scans 2..6.
    toScan(1);  keys = kb(9); expPulse(0, 4, 9);
    toScan(3);  check("press_early_valid", bus0.key_valid, 0);
    toScan(4);  check("press_valid", bus0.key_valid, 1);
                check("press_code", bus0.key_code, 9);
    toScan(6);  keys = '0;
    toScan(8);  check("release_pending", bus0.key_valid, 1);
    toScan(9);  check("release_valid", bus0.key_valid, 0);
                check("release_code_hold", bus0.key_code, 9);

    // Bounce: key 6 flips every scan, scans 10..15.
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? kb(6) : '0;
      toScan(10 + i);
      check("bounce_valid", bus0.key_valid, 0);
    end

    // Chord 0+5 for scans 16..19.
    keys = kb(0) | kb(5);
    toScan(17); check("chord_early", bus0.multi_key, 0);
    toScan(18); check("chord_multi", bus0.multi_key, 1);
                check("chord_valid", bus0.key_valid, 0);
    toScan(19); keys = '0;
    toScan(21); check("chord_hold", bus0.multi_key, 1);
    toScan(22); check("chord_clear", bus0.multi_key, 0);

    // Rollover: 3 then 7 with no gap; 7 only reported after a release.
    keys = kb(3); expPulse(0, 25, 3);
    toScan(25); check("roll_valid", bus0.key_valid, 1);
                check("roll_code", bus0.key_code, 3);
                keys = kb(7);
    toScan(28); check("roll_no_change", bus0.key_code, 3);
                keys = '0;
    toScan(30); check("roll_held", bus0.key_valid, 1);
    toScan(31); check("roll_release", bus0.key_valid, 0);
                check("roll_code_hold", bus0.key_code, 3);
                keys = kb(7); expPulse(0, 34, 7);
    toScan(34); check("roll_fresh_code", bus0.key_code, 7);
                keys = '0;
    toScan(37); check("roll_fresh_release", bus0.key_valid, 0);

    // Repeat: key 15 for scans 38..49; the release commits at 52, so the
    // scanner is still held at 50 and that repeat still fires.
    repOn = 1'b1; keys = kb(15);
    expPulse(0, 40, 15);
    expPulse(1, 40, 15); expPulse(1, 44, 15); expPulse(1, 46, 15);
    expPulse(1, 48, 15); expPulse(1, 50, 15);
    toScan(40); check("rpt_valid", bus1.key_valid, 1);
                check("rpt_code", bus1.key_code, 15);
    toScan(49); keys = '0;
    toScan(52); check("rpt_release1", bus1.key_valid, 0);
                check("rpt_release0", bus0.key_valid, 0);
    toScan(55); repOn = 1'b0;

    // Reset mid-dwell while key 2 is held; it must re-debounce afterwards.
    keys = kb(2); expPulse(0, 58, 2);
    toScan(58); check("pre_reset_valid", bus0.key_valid, 1);
    toCyc(58 * T + 6);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cols",  bus0.cols, 1);
    check("mid_rst_code",  bus0.key_code, 0);
    check("mid_rst_valid", bus0.key_valid, 0);
    check("mid_rst_pulse", bus0.key_pulse, 0);
    check("mid_rst_multi", bus0.multi_key, 0);
    repeat (3) @(negedge clk);
    expPulse(0, 3, 2);
    rst = 1'b1;
    chkRotation();
    toScan(2);  check("redeb_early", bus0.key_valid, 0);
    toScan(3);  check("redeb_valid", bus0.key_valid, 1);
                check("redeb_code", bus0.key_code, 2);
                keys = '0;
    toScan(6);  check("redeb_release", bus0.key_valid, 0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
